if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core; sits directly upstream of the ID-stage control decoder.
- Holds the PC, drives the instruction-memory address, and selects next PC: sequential, taken branch, j, jal or jr.
- Latches the fetched instruction and PC+4 into IF/ID, and squashes the wrong-path instruction on any redirect.
- Drives id_bubble, which the decoder uses as its ctrl input to zero all control signals for a squashed slot.

---
 rtl/if_stage_pkg.sv | 18 +
 rtl/next_pc_sel.sv | 49 ++++
 rtl/if_stage.sv | 90 +++++++++
 tb/tb_if_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants for the fetch stage: jump encodings common with the
// control decoder, reset defaults and the fetch FSM state type.
package if_stage_pkg;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_J    = 2'b01;
  localparam logic [1:0] JUMP_JR   = 2'b10;
  localparam logic [1:0] JUMP_JAL  = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC computation: sequential, taken branch, j/jal and jr,
// with jumps taking priority over a taken branch.
module next_pc_sel
  import if_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] id_pc4,
  input  logic [31:0] id_instr,
  input  logic [31:0] jr_target,
  input  logic [1:0]  jump,
  input  logic        branch_taken,
  input  logic        slot_live,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        redirect
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_aligned;
  logic        unused_bits;

  assign unused_bits = ^{id_instr[31:26], jr_target[1:0]};

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = id_pc4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
  assign jump_target   = {id_pc4[31:28], id_instr[25:0], 2'b00};
  assign jr_aligned    = {jr_target[31:2], 2'b00};

  // A request only counts when IF/ID holds a real instruction; a bubble
  // slot can never redirect, which rules out back-to-back redirects.
  always_comb begin
    next_pc  = pc_plus4;
    redirect = 1'b0;
    if (slot_live) begin
      if (jump == JUMP_J || jump == JUMP_JAL) begin
        next_pc  = jump_target;
        redirect = 1'b1;
      end else if (jump == JUMP_JR) begin
        next_pc  = jr_aligned;
        redirect = 1'b1;
      end else if (branch_taken) begin
        next_pc  = branch_target;
        redirect = 1'b1;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register, redirect squash
// and a fetch performance counter.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [1:0]  jump,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic        id_bubble,
  output logic [31:0] fetch_count
);

  logic [31:0]  pc;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         redirect;
  logic         slot_live;
  logic         load_en;
  fetch_state_t state;
  fetch_state_t state_next;

  assign imem_addr = pc;
  assign slot_live = id_valid & ~id_bubble;
  // The first edge after reset always loads; a stall has nothing to hold yet.
  assign load_en   = (state == FILL) | ~stall;

  next_pc_sel u_next_pc_sel (
    .pc           (pc),
    .id_pc4       (id_pc4),
    .id_instr     (id_instr),
    .jr_target    (jr_target),
    .jump         (jump),
    .branch_taken (branch_taken),
    .slot_live    (slot_live),
    .pc_plus4     (pc_plus4),
    .next_pc      (next_pc),
    .redirect     (redirect)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      id_instr    <= NOP_WORD;
      id_pc4      <= 32'h0000_0000;
      id_valid    <= 1'b0;
      id_bubble   <= 1'b1;
      fetch_count <= 32'h0000_0000;
    end else if (redirect) begin
      // No delay slot: the word fetched this cycle is dropped, and id_pc4
      // keeps the jal link value.
      pc        <= next_pc;
      id_instr  <= NOP_WORD;
      id_valid  <= 1'b0;
      id_bubble <= 1'b1;
    end else if (load_en) begin
      pc          <= next_pc;
      id_instr    <= imem_rdata;
      id_pc4      <= pc_plus4;
      id_valid    <= 1'b1;
      id_bubble   <= 1'b0;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      FILL:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = FILL;
    endcase
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: table of per-edge vectors with a
// scoreboard queue, plus hand-written reset sequences.
module tb_if_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        bubble;
    logic [31:0] cnt;
  } exp_t;

  typedef struct packed {
    logic        stall;
    logic        br;
    logic [1:0]  jmp;
    logic [31:0] jr;
    logic        pre_reset;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [1:0]  jump;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        id_bubble;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:1023];
  vec_t        table_q[$];
  exp_t        exp_q[$];
  int          n_checks;
  int          n_passed;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .jump         (jump),
    .jr_target    (jr_target),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .id_instr     (id_instr),
    .id_pc4       (id_pc4),
    .id_valid     (id_valid),
    .id_bubble    (id_bubble),
    .fetch_count  (fetch_count)
  );

  assign imem_rdata = mem[imem_addr[11:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input logic s, input logic b, input logic [1:0] j,
                        input logic [31:0] jr, input logic pr,
                        input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] pc4, input logic v, input logic bb,
                        input logic [31:0] c);
    vec_t t;
    t.stall = s; t.br = b; t.jmp = j; t.jr = jr; t.pre_reset = pr;
    t.e.pc = pc; t.e.instr = instr; t.e.pc4 = pc4;
    t.e.valid = v; t.e.bubble = bb; t.e.cnt = c;
    table_q.push_back(t);
  endtask

  task automatic addRun(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] pc4, input logic [31:0] c);
    addVec(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, pc, instr, pc4, 1'b1, 1'b0, c);
  endtask

  function automatic exp_t resetExp();
    exp_t r;
    r.pc = 32'h0; r.instr = 32'h0; r.pc4 = 32'h0;
    r.valid = 1'b0; r.bubble = 1'b1; r.cnt = 32'h0;
    return r;
  endfunction

  task automatic applyStimulus(input vec_t v);
    stall        = v.stall;
    branch_taken = v.br;
    jump         = v.jmp;
    jr_target    = v.jr;
    exp_q.push_back(v.e);
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL %s: scoreboard empty, got output with no expectation", name);
      return;
    end
    e = exp_q.pop_front();
    if (imem_addr === e.pc && id_instr === e.instr && id_pc4 === e.pc4 &&
        id_valid === e.valid && id_bubble === e.bubble && fetch_count === e.cnt) begin
      n_passed++;
    end else begin
      $display("[TB] FAIL %s: got pc=%h instr=%h pc4=%h v=%b b=%b cnt=%0d, required pc=%h instr=%h pc4=%h v=%b b=%b cnt=%0d",
               name, imem_addr, id_instr, id_pc4, id_valid, id_bubble, fetch_count,
               e.pc, e.instr, e.pc4, e.valid, e.bubble, e.cnt);
    end
  endtask

  initial begin
    n_checks = 0;
    n_passed = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
    mem[0]    = 32'h2008_0001;
    mem[1]    = 32'h2009_0002;
    mem[2]    = 32'h0109_5020;
    mem[3]    = 32'h0000_0000;
    mem[7]    = 32'h0800_0040;
    mem[12'h41] = 32'h0C00_0040;

    // Free run from reset, real nop at 0xC
    addRun(32'h04, 32'h2008_0001, 32'h04, 1);
    addRun(32'h08, 32'h2009_0002, 32'h08, 2);
    addRun(32'h0C, 32'h0109_5020, 32'h0C, 3);
    addRun(32'h10, 32'h0000_0000, 32'h10, 4);
    // Re-reset with beq at 0xC, then taken branch back to 0x08
    addVec(1'b0, 1'b0, 2'b00, 32'h0, 1'b1, 32'h04, 32'h2008_0001, 32'h04, 1'b1, 1'b0, 1);
    addRun(32'h08, 32'h2009_0002, 32'h08, 2);
    addRun(32'h0C, 32'h0109_5020, 32'h0C, 3);
    addRun(32'h10, 32'h1109_FFFE, 32'h10, 4);
    addVec(1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 32'h08, 32'h0, 32'h10, 1'b0, 1'b1, 4);
    addRun(32'h0C, 32'h0109_5020, 32'h0C, 5);
    addRun(32'h10, 32'h1109_FFFE, 32'h10, 6);
    addRun(32'h14, 32'hA000_0004, 32'h14, 7);
    addRun(32'h18, 32'hA000_0005, 32'h18, 8);
    addRun(32'h1C, 32'hA000_0006, 32'h1C, 9);
    addRun(32'h20, 32'h0800_0040, 32'h20, 10);
    // j and jal to 0x100, link value held
    addVec(1'b0, 1'b0, 2'b01, 32'h0, 1'b0, 32'h100, 32'h0, 32'h20, 1'b0, 1'b1, 10);
    addRun(32'h104, 32'hA000_0040, 32'h104, 11);
    addRun(32'h108, 32'h0C00_0040, 32'h108, 12);
    addVec(1'b0, 1'b0, 2'b11, 32'h0, 1'b0, 32'h100, 32'h0, 32'h108, 1'b0, 1'b1, 12);
    addRun(32'h104, 32'hA000_0040, 32'h104, 13);
    // jr with unaligned target, redirect beats stall, then stall alone
    addVec(1'b0, 1'b0, 2'b10, 32'h203, 1'b0, 32'h200, 32'h0, 32'h104, 1'b0, 1'b1, 13);
    addRun(32'h204, 32'hA000_0080, 32'h204, 14);
    addVec(1'b1, 1'b1, 2'b00, 32'h0, 1'b0, 32'h404, 32'h0, 32'h204, 1'b0, 1'b1, 14);
    addRun(32'h408, 32'hA000_0101, 32'h408, 15);
    for (int k = 0; k < 3; k++)
      addVec(1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 32'h408, 32'hA000_0101, 32'h408, 1'b1, 1'b0, 15);
    // jr near top of memory, branch ignored in bubble, PC wraps to 0
    addVec(1'b0, 1'b0, 2'b10, 32'hFFFF_FFF9, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h408, 1'b0, 1'b1, 15);
    addVec(1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 32'hFFFF_FFFC, 32'hA000_03FE, 32'hFFFF_FFFC, 1'b1, 1'b0, 16);
    addRun(32'h0, 32'hA000_03FF, 32'h0, 17);
    // j keeps id_pc4[31:28] as the region bits
    addVec(1'b0, 1'b0, 2'b10, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0, 1'b1, 17);
    addRun(32'hFFFF_FFFC, 32'hA000_03FE, 32'hFFFF_FFFC, 18);
    addVec(1'b0, 1'b0, 2'b01, 32'h0, 1'b0, 32'hF000_0FF8, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b1, 18);
    addRun(32'hF000_0FFC, 32'hA000_03FE, 32'hF000_0FFC, 19);

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 2'b00; jr_target = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(resetExp());
    checkOutput("reset_state");
    rst = 1'b0;

    for (int i = 0; i < table_q.size(); i++) begin
      if (table_q[i].pre_reset) begin
        mem[3] = 32'h1109_FFFE;
        rst = 1'b1;
        #1;
        exp_q.push_back(resetExp());
        checkOutput("rereset_state");
        rst = 1'b0;
      end
      applyStimulus(table_q[i]);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-cycle during a stall
    stall = 1'b1; branch_taken = 1'b0; jump = 2'b00;
    #3;
    rst = 1'b1;
    #1;
    exp_q.push_back(resetExp());
    checkOutput("async_reset_midcycle");
    @(posedge clk);
    #1;
    exp_q.push_back(resetExp());
    checkOutput("reset_held_over_edge");
    rst = 1'b0;
    stall = 1'b0;
    begin
      exp_t e;
      e.pc = 32'h4; e.instr = 32'h2008_0001; e.pc4 = 32'h4;
      e.valid = 1'b1; e.bubble = 1'b0; e.cnt = 32'd1;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    checkOutput("fill_after_reset");

    $display("[TB] %0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
